matmul_mem_ctrl: RTL and testbench
==================================

Name: matmul_mem_ctrl

Overview:
Parametrised memory-and-control shell for the systolic matmul engine. Holds NUM_BANKS dual-port BRAM banks: port 0 of every bank faces the compute engine, and port 1 is shared by the host through a bank selector. Provides the start/busy/done/clear handshake that sequences one engine run. Successor to the fixed 3-bank, 4-lane shell, adding:
- per-lane write enables
- a registered read-select
- host lockout while the engine runs

Parameters:
DWIDTH, 8, bits per matrix element
LANES, 4, elements per BRAM word (word width W = LANES*DWIDTH)
AWIDTH, 10, BRAM address bits (depth 2**AWIDTH)
NUM_BANKS, 3, number of BRAM banks (A, B, C, ...); range 1..4
SELW, 2, bank-select width; must satisfy 2**SELW >= NUM_BANKS

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
start_reg  in  1  level request to start a run
clear_done_reg  in  1  acknowledges done and returns the block to IDLE
busy  out  1  high in START and RUN
done  out  1  high in DONE
ext_err  out  1  sticky; set by a host write blocked during busy or to an invalid bank
ext_sel  in  SELW  host bank select
ext_addr  in  AWIDTH  host address
ext_we  in  LANES  host per-lane write enable
ext_wdata  in  W  host write data
ext_rdata  out  W  host read data
core_start  out  1  engine start, held high until core_done
core_done  in  1  engine completion
core_addr  in  NUM_BANKS*AWIDTH  engine address per bank, bank i at slice [i*AWIDTH +: AWIDTH]
core_we  in  NUM_BANKS*LANES  engine lane enables per bank
core_wdata  in  NUM_BANKS*W  engine write data per bank
core_rdata  out  NUM_BANKS*W  engine read data per bank

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; busy=0, done=0, core_start=0, ext_err=0
  - ext_rdata=0, core_rdata=0, registered select=0
  - BRAM contents are not cleared.
- FSM:
  - IDLE -> START when start_reg=1.
  - START (one cycle): core_start<=1, then -> RUN.
  - RUN: core_start stays 1. When core_done=1: core_start<=0 and -> DONE.
  - DONE: -> IDLE when clear_done_reg=1.
  - Illegal encodings -> IDLE.
- core_done seen in IDLE, START or DONE is ignored.
- start_reg held high through DONE does not restart until the block has passed through IDLE. If clear_done_reg and start_reg are both high in DONE, the sequence is DONE -> IDLE -> START on consecutive cycles.
- Memory write gating:
  - Engine writes to BRAM are gated by (state==RUN). core_we outside RUN is dropped.
  - Host writes are gated by !busy and ext_sel<NUM_BANKS.
  - A blocked host write (any ext_we bit set) sets ext_err. ext_err clears only on reset.
  - Because of this gating, same-address dual-port write collisions cannot occur.
- Per-lane writes: lane k (bits [k*DWIDTH +: DWIDTH]) is written only when we[k]=1; the other lanes keep their old value.
- Read latency is 1 cycle on both ports, read-before-write: q shows the old word on a write cycle.
- ext_sel is registered alongside the read. ext_rdata returns the bank selected in the issue cycle, so ext_sel may change every cycle.
- An invalid registered select returns ext_rdata=0.
- Host reads are allowed while busy (reads are non-intrusive).
- Reset mid-RUN: core_start drops asynchronously; the engine is expected to be reset with the same signal.

Optional Feature:
MATMUL_CYCLE_COUNT_EN
- When defined:
  - Adds output run_cycles[31:0].
  - Cleared on entry to START; increments every RUN cycle, saturating at 0xFFFFFFFF.
  - Frozen in DONE and IDLE until the next START; reset value 0.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package matmul_pkg holds:
  - DWIDTH, LANES, AWIDTH, NUM_BANKS defaults
  - FSM state encoding: IDLE=2'd0, START=2'd1, RUN=2'd2, DONE=2'd3
  - bank index constants BANK_A=0, BANK_B=1, BANK_C=2
- One sub-module, matmul_dp_ram: lane-masked, true dual-port, read-before-write BRAM, instantiated NUM_BANKS times in a generate loop.

Test Plan:
1. Host write, lane mask and readback:
   - Stimulus: reset; write bank 0 addr 5 = 0x11223344 with ext_we=4'b1111; then write addr 5 = 0xAABBCCDD with ext_we=4'b0101; read addr 5.
   - Response: ext_rdata=0x11BB33DD exactly one cycle after the read is issued.
2. Handshake and core write gating:
   - Stimulus: pulse start_reg.
   - Response: busy=1 one cycle later; core_start=1 the cycle after that.
   - Stimulus: engine writes bank 2 addr 0 = 0x01020304, then core_done=1.
   - Response: done=1, core_start=0; host read of bank 2 addr 0 returns 0x01020304.
3. Lockout:
   - Stimulus: during RUN, host writes bank 0 addr 5 = 0xFFFFFFFF.
   - Response: ext_err=1; after clear_done_reg, reading addr 5 still returns 0x11BB33DD.
4. Registered select:
   - Stimulus: write 0xA0/0xB0/0xC0 at addr 1 of banks 0/1/2; issue reads with ext_sel=0,1,2,3 on back-to-back cycles.
   - Response: ext_rdata = 0xA0, 0xB0, 0xC0, 0 on the following cycles.
5. Reset mid-RUN:
   - Stimulus: assert reset asynchronously mid-RUN.
   - Response: core_start, busy and done fall to 0 before the next edge; BRAM contents are preserved; a new start_reg runs normally.
6. MATMUL_CYCLE_COUNT_EN:
   - Stimulus: keep core_done low for 20 RUN cycles, then assert it.
   - Response: run_cycles=20, holding in DONE.

Source files
------------

// File: rtl/matmul_mem_ctrl_pkg.sv
// Shared definitions for the matmul memory/control shell: default sizes,
// the run-sequencer state encoding and the bank index names.
package matmul_pkg;

  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_LANES     = 4;
  localparam int DEF_AWIDTH    = 10;
  localparam int DEF_NUM_BANKS = 3;
  localparam int DEF_SELW      = 2;

  // Run sequencer states; all four 2-bit codes are used.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BANK_A = 0;
  localparam int BANK_B = 1;
  localparam int BANK_C = 2;

endpackage

// File: rtl/matmul_dp_ram.sv
// Lane-masked true dual-port RAM, read-before-write on both ports,
// one-cycle read latency. Output registers reset to zero; the array does not.
module matmul_dp_ram #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 4,
  parameter int AWIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AWIDTH-1:0]         i_addr_a,
  input  logic [LANES-1:0]          i_we_a,
  input  logic [LANES*DWIDTH-1:0]   i_wdata_a,
  output logic [LANES*DWIDTH-1:0]   o_q_a,
  input  logic [AWIDTH-1:0]         i_addr_b,
  input  logic [LANES-1:0]          i_we_b,
  input  logic [LANES*DWIDTH-1:0]   i_wdata_b,
  output logic [LANES*DWIDTH-1:0]   o_q_b
);

  localparam int W     = LANES * DWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  logic [W-1:0] r_mem [DEPTH];

  // Lane-masked writes from both ports; the shell never lets both ports
  // write the same word in one cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (i_we_a[k]) r_mem[i_addr_a][k*DWIDTH +: DWIDTH] <= i_wdata_a[k*DWIDTH +: DWIDTH];
      if (i_we_b[k]) r_mem[i_addr_b][k*DWIDTH +: DWIDTH] <= i_wdata_b[k*DWIDTH +: DWIDTH];
    end
  end

  // Registered reads; a same-cycle write is not visible until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q_a <= '0;
      o_q_b <= '0;
    end else begin
      o_q_a <= r_mem[i_addr_a];
      o_q_b <= r_mem[i_addr_b];
    end
  end

endmodule

// File: rtl/matmul_mem_ctrl.sv
// Memory-and-control shell for the systolic matmul engine.
// Port 0 of each bank belongs to the engine, port 1 to the host via ext_sel.
// Optional build macro MATMUL_CYCLE_COUNT_EN adds the run_cycles counter.
//
// Run handshake: the host raises start_reg (level); busy goes high in START
// and RUN; core_start is held high through RUN until the engine returns
// core_done; done stays high until the host answers with clear_done_reg.
// A start_reg still high in DONE only restarts after passing through IDLE.
module matmul_mem_ctrl
  import matmul_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int SELW      = DEF_SELW,
  parameter int W         = LANES * DWIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_reg,
  input  logic                        clear_done_reg,
  output logic                        busy,
  output logic                        done,
  output logic                        ext_err,
  input  logic [SELW-1:0]             ext_sel,
  input  logic [AWIDTH-1:0]           ext_addr,
  input  logic [LANES-1:0]            ext_we,
  input  logic [W-1:0]                ext_wdata,
  output logic [W-1:0]                ext_rdata,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic [NUM_BANKS*AWIDTH-1:0] core_addr,
  input  logic [NUM_BANKS*LANES-1:0]  core_we,
  input  logic [NUM_BANKS*W-1:0]      core_wdata,
  output logic [NUM_BANKS*W-1:0]      core_rdata,
  output logic [1:0]                  o_dbg_state
`ifdef MATMUL_CYCLE_COUNT_EN
  ,
  output logic [31:0]                 run_cycles
`endif
);

  localparam logic [SELW:0] L_NUM_BANKS = (SELW+1)'(NUM_BANKS);

  if (NUM_BANKS < 1 || NUM_BANKS > 4 || (1 << SELW) < NUM_BANKS) begin : g_bad_cfg
    $error("matmul_mem_ctrl: NUM_BANKS must be 1..4 and fit in SELW bits");
  end

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_core_start;
  logic            r_ext_err;
  logic [SELW-1:0] r_sel;

  logic            w_sel_ok;
  logic            w_host_ok;
  logic            w_core_ok;
  logic [W-1:0]    w_q_b [NUM_BANKS];
  logic [W-1:0]    w_ext_rdata;

  assign w_sel_ok  = ({1'b0, ext_sel} < L_NUM_BANKS);
  assign w_host_ok = !r_busy && w_sel_ok;
  assign w_core_ok = (r_state == ST_RUN);

  // Run sequencer with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_reg) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          r_state      <= ST_RUN;
          r_core_start <= 1'b1;
        end
        ST_RUN: begin
          if (core_done) begin
            r_state      <= ST_DONE;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        ST_DONE: begin
          if (clear_done_reg) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_core_start <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error for any host write attempt that the gating refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_err <= 1'b0;
    end else if ((|ext_we) && !w_host_ok) begin
      r_ext_err <= 1'b1;
    end
  end

  // Host select travels with the read so ext_rdata matches the issue cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= '0;
    end else begin
      r_sel <= ext_sel;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [LANES-1:0] w_we_a;
    logic [LANES-1:0] w_we_b;

    assign w_we_a = w_core_ok ? core_we[g*LANES +: LANES] : '0;
    assign w_we_b = (w_host_ok && (ext_sel == SELW'(g))) ? ext_we : '0;

    matmul_dp_ram #(
      .DWIDTH (DWIDTH),
      .LANES  (LANES),
      .AWIDTH (AWIDTH)
    ) u_ram (
      .clk       (clk),
      .rst       (reset),
      .i_addr_a  (core_addr[g*AWIDTH +: AWIDTH]),
      .i_we_a    (w_we_a),
      .i_wdata_a (core_wdata[g*W +: W]),
      .o_q_a     (core_rdata[g*W +: W]),
      .i_addr_b  (ext_addr),
      .i_we_b    (w_we_b),
      .i_wdata_b (ext_wdata),
      .o_q_b     (w_q_b[g])
    );
  end

  // Host read mux; a select beyond the last bank yields zero.
  always_comb begin
    w_ext_rdata = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_sel == SELW'(i)) w_ext_rdata = w_q_b[i];
    end
  end

`ifdef MATMUL_CYCLE_COUNT_EN
  logic [31:0] r_run_cycles;

  // Counts RUN cycles the engine spends working before it reports done;
  // cleared on the way into START, frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_cycles <= '0;
    end else if (r_state == ST_IDLE && start_reg) begin
      r_run_cycles <= '0;
    end else if (r_state == ST_RUN && !core_done && r_run_cycles != 32'hFFFF_FFFF) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign core_start  = r_core_start;
  assign ext_err     = r_ext_err;
  assign ext_rdata   = w_ext_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Bench for matmul_mem_ctrl: directed handshake/lockout/select/reset cases
// followed by randomized traffic, all compared against an in-bench model.
module tb_matmul_mem_ctrl;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int AW = 10;
  localparam int NB = 3;
  localparam int SW = 2;
  localparam int W  = LN * DW;

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start_reg = 1'b0;
  logic              clear_done_reg = 1'b0;
  logic              busy, done, ext_err, core_start;
  logic [SW-1:0]     ext_sel = '0;
  logic [AW-1:0]     ext_addr = '0;
  logic [LN-1:0]     ext_we = '0;
  logic [W-1:0]      ext_wdata = '0;
  logic [W-1:0]      ext_rdata;
  logic              core_done = 1'b0;
  logic [NB*AW-1:0]  core_addr = '0;
  logic [NB*LN-1:0]  core_we = '0;
  logic [NB*W-1:0]   core_wdata = '0;
  logic [NB*W-1:0]   core_rdata;
  logic [1:0]        dbg_state;

  matmul_mem_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start_reg      (start_reg),
    .clear_done_reg (clear_done_reg),
    .busy           (busy),
    .done           (done),
    .ext_err        (ext_err),
    .ext_sel        (ext_sel),
    .ext_addr       (ext_addr),
    .ext_we         (ext_we),
    .ext_wdata      (ext_wdata),
    .ext_rdata      (ext_rdata),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_addr      (core_addr),
    .core_we        (core_we),
    .core_wdata     (core_wdata),
    .core_rdata     (core_rdata),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_data = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_phase = PH_IDLE;
  logic         m_err   = 1'b0;
  logic [W-1:0] m_mem [NB][1<<AW];
  logic [W-1:0] exp_ext = '0;
  logic [W-1:0] exp_core [NB] = '{default: '0};

  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] old_w,
                                               input logic [W-1:0] new_w,
                                               input logic [LN-1:0] we);
    logic [W-1:0] r;
    r = old_w;
    for (int k = 0; k < LN; k++) if (we[k]) r[k*DW +: DW] = new_w[k*DW +: DW];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_IDLE;
      m_err   = 1'b0;
      exp_ext = '0;
      for (int b = 0; b < NB; b++) exp_core[b] = '0;
    end else begin
      // reads return the word as it stood before this cycle's writes
      exp_ext = (int'(ext_sel) < NB) ? m_mem[ext_sel][ext_addr] : '0;
      for (int b = 0; b < NB; b++) exp_core[b] = m_mem[b][core_addr[b*AW +: AW]];
      if (|ext_we) begin
        if (m_phase == PH_START || m_phase == PH_RUN || int'(ext_sel) >= NB)
          m_err = 1'b1;
        else
          m_mem[ext_sel][ext_addr] = lane_merge(m_mem[ext_sel][ext_addr], ext_wdata, ext_we);
      end
      if (m_phase == PH_RUN) begin
        for (int b = 0; b < NB; b++)
          m_mem[b][core_addr[b*AW +: AW]] = lane_merge(m_mem[b][core_addr[b*AW +: AW]],
                                                       core_wdata[b*W +: W], core_we[b*LN +: LN]);
      end
      case (m_phase)
        PH_IDLE:  if (start_reg) m_phase = PH_START;
        PH_START: m_phase = PH_RUN;
        PH_RUN:   if (core_done) m_phase = PH_DONE;
        default:  if (clear_done_reg) m_phase = PH_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("busy",       W'(busy),       W'(m_phase == PH_START || m_phase == PH_RUN));
      check("done",       W'(done),       W'(m_phase == PH_DONE));
      check("core_start", W'(core_start), W'(m_phase == PH_RUN));
      check("ext_err",    W'(ext_err),    W'(m_err));
      check("state",      W'(dbg_state),  W'(m_phase));
      if (chk_data) begin
        check("ext_rdata", ext_rdata, exp_ext);
        for (int b = 0; b < NB; b++) check("core_rdata", core_rdata[b*W +: W], exp_core[b]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_wr(input int sel, input int addr, input logic [LN-1:0] we, input logic [W-1:0] d);
    ext_sel   = SW'(sel);
    ext_addr  = AW'(addr);
    ext_we    = we;
    ext_wdata = d;
    @(negedge clk);
    ext_we = '0;
  endtask

  task automatic host_rd_check(input string name, input int sel, input int addr, input logic [W-1:0] exp);
    ext_sel  = SW'(sel);
    ext_addr = AW'(addr);
    ext_we   = '0;
    @(negedge clk);
    check(name, ext_rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] sel_exp [4];

  initial begin
    sel_exp[0] = 32'h0000_00A0;
    sel_exp[1] = 32'h0000_00B0;
    sel_exp[2] = 32'h0000_00C0;
    sel_exp[3] = 32'h0000_0000;

    repeat (3) @(negedge clk);
    check("rst_busy",       W'(busy), '0);
    check("rst_done",       W'(done), '0);
    check("rst_core_start", W'(core_start), '0);
    check("rst_ext_err",    W'(ext_err), '0);
    check("rst_ext_rdata",  ext_rdata, '0);
    for (int b = 0; b < NB; b++) check("rst_core_rdata", core_rdata[b*W +: W], '0);
    reset = 1'b0;
    @(negedge clk);

    // known contents for the address window used by the bench
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 16; a++)
        host_wr(b, a, 4'b1111, $urandom);
    repeat (2) @(negedge clk);
    chk_data = 1'b1;

    // lane mask and readback
    host_wr(0, 5, 4'b1111, 32'h1122_3344);
    host_wr(0, 5, 4'b0101, 32'hAABB_CCDD);
    host_rd_check("lane_mask", 0, 5, 32'h11BB_33DD);

    // handshake, engine write, lockout
    start_reg = 1'b1;
    @(negedge clk);
    start_reg = 1'b0;
    check("hs_busy", W'(busy), W'(1));
    check("hs_core_start_lo", W'(core_start), W'(0));
    @(negedge clk);
    check("hs_core_start_hi", W'(core_start), W'(1));
    core_addr[2*AW +: AW]  = '0;
    core_we[2*LN +: LN]    = 4'b1111;
    core_wdata[2*W +: W]   = 32'h0102_0304;
    @(negedge clk);
    core_we = '0;
    host_wr(0, 5, 4'b1111, 32'hFFFF_FFFF);
    check("lock_err", W'(ext_err), W'(1));
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("hs_done", W'(done), W'(1));
    check("hs_core_start_off", W'(core_start), W'(0));
    host_rd_check("core_wr_readback", 2, 0, 32'h0102_0304);
    clear_done_reg = 1'b1;
    @(negedge clk);
    clear_done_reg = 1'b0;
    host_rd_check("lock_preserved", 0, 5, 32'h11BB_33DD);

    // registered select, back to back
    host_wr(0, 1, 4'b1111, 32'h0000_00A0);
    host_wr(1, 1, 4'b1111, 32'h0000_00B0);
    host_wr(2, 1, 4'b1111, 32'h0000_00C0);
    for (int s = 0; s < 4; s++) host_rd_check("sel_rd", s, 1, sel_exp[s]);

    // reset in the middle of a run
    start_reg = 1'b1;
    @(negedge clk);
    start_reg = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_core_start", W'(core_start), '0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("arst_err_clr", W'(ext_err), '0);
    host_rd_check("arst_mem_kept", 0, 5, 32'h11BB_33DD);
    start_reg = 1'b1;
    @(negedge clk);
    start_reg = 1'b0;
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("rerun_done", W'(done), W'(1));
    clear_done_reg = 1'b1;
    @(negedge clk);
    clear_done_reg = 1'b0;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      start_reg      = ($urandom_range(0, 3) == 0);
      clear_done_reg = ($urandom_range(0, 3) == 0);
      core_done      = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < NB; b++) begin
        core_addr[b*AW +: AW] = AW'($urandom_range(0, 15));
        core_we[b*LN +: LN]   = ($urandom_range(0, 1) == 1) ? LN'($urandom) : '0;
        core_wdata[b*W +: W]  = $urandom;
      end
      ext_sel   = SW'($urandom_range(0, 3));
      ext_addr  = AW'($urandom_range(0, 15));
      ext_we    = ($urandom_range(0, 2) == 0) ? LN'($urandom) : '0;
      ext_wdata = $urandom;
      @(negedge clk);
    end
    start_reg = 1'b0;
    core_we   = '0;
    ext_we    = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
